// File: rtl/instr_buffer.sv
// Instruction buffer between fetch and decode: a circular queue that accepts up to
// two instructions per cycle and presents the oldest one to the decoder.
module instr_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic [1:0]                 fetch_valid_i,
    input  logic [1:0][31:0]           fetch_instr_i,
    input  logic [1:0][31:0]           fetch_pc_i,
    output logic                       fetch_ready_o,
    output logic                       dec_valid_o,
    output logic [31:0]                dec_instr_o,
    output logic [31:0]                dec_pc_o,
    input  logic                       dec_ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          push;
    logic          pop;
    logic [1:0]    n_push;
    logic          wr0_en, wr1_en;
    logic [PW-1:0] wr0_idx, wr1_idx;
    logic [31:0]   wr0_instr, wr0_pc;

    // Ready only when a full two-lane packet fits, so it never depends on a same-cycle pop.
    assign fetch_ready_o = (count_q <= CW'(DEPTH - 2));
    assign dec_valid_o   = (count_q != '0);
    assign count_o       = count_q;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        n_push    = 2'd0;
        wr0_en    = 1'b0;
        wr1_en    = 1'b0;
        wr0_idx   = tail_q;
        wr1_idx   = tail_q + PW'(1);
        wr0_instr = fetch_instr_i[0];
        wr0_pc    = fetch_pc_i[0];
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        push   = fetch_ready_o && (fetch_valid_i != 2'b00) && !flush_i;
        pop    = dec_valid_o && dec_ready_i && !flush_i;
        n_push = push ? (2'(fetch_valid_i[0]) + 2'(fetch_valid_i[1])) : 2'd0;

        // A lone lane-1 instruction still lands at the tail slot.
        if (!fetch_valid_i[0]) begin
            wr0_instr = fetch_instr_i[1];
            wr0_pc    = fetch_pc_i[1];
        end
        wr0_en = push;
        wr1_en = push && (fetch_valid_i == 2'b11);

        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(n_push);
        count_d = count_q + CW'(n_push) - CW'(pop);

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_comb begin
        dec_instr_o = 32'h0;
        dec_pc_o    = 32'h0;
        if (dec_valid_o) begin
            dec_instr_o = instr_mem_q[head_q];
            dec_pc_o    = pc_mem_q[head_q];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (wr0_en && !rst) begin
            instr_mem_q[wr0_idx] <= wr0_instr;
            pc_mem_q[wr0_idx]    <= wr0_pc;
        end
        if (wr1_en && !rst) begin
            instr_mem_q[wr1_idx] <= fetch_instr_i[1];
            pc_mem_q[wr1_idx]    <= fetch_pc_i[1];
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer (DEPTH = 8): a vector table plus hand-written
// sequences for fill/drain, steady-state wrap-around and reset/flush corners.
module tb_instr_buffer;

    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush_i;
    logic [1:0]       fetch_valid_i;
    logic [1:0][31:0] fetch_instr_i;
    logic [1:0][31:0] fetch_pc_i;
    logic             fetch_ready_o;
    logic             dec_valid_o;
    logic [31:0]      dec_instr_o;
    logic [31:0]      dec_pc_o;
    logic             dec_ready_i;
    logic [3:0]       count_o;

    int n_cmp  = 0;
    int n_fail = 0;

    instr_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_instr_i (fetch_instr_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_ready_o (fetch_ready_o),
        .dec_valid_o   (dec_valid_o),
        .dec_instr_o   (dec_instr_o),
        .dec_pc_o      (dec_pc_o),
        .dec_ready_i   (dec_ready_i),
        .count_o       (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [1:0]  valid;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic        rdy;
        int          exp_cnt;
        logic        exp_v;
        logic [31:0] exp_pc;
        logic        exp_fr;
    } vec_t;

    vec_t vecs [18];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'hA5A5_A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic [1:0] v,
                         input logic [31:0] p0, input logic [31:0] p1, input logic rdy);
        rst              = r;
        flush_i          = f;
        fetch_valid_i    = v;
        fetch_pc_i[0]    = p0;
        fetch_pc_i[1]    = p1;
        fetch_instr_i[0] = instr_of(p0);
        fetch_instr_i[1] = instr_of(p1);
        dec_ready_i      = rdy;
    endtask

    // Inputs change at negedge; outputs are sampled at the following negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        tick();
        idle();
    endtask

    task automatic check_head(input string name, input int cnt, input logic [31:0] pc, input logic fr);
        check({name, ".count"}, 32'(count_o), 32'(cnt));
        check({name, ".valid"}, 32'(dec_valid_o), 32'(cnt != 0));
        check({name, ".pc"}, dec_pc_o, (cnt != 0) ? pc : 32'h0);
        check({name, ".instr"}, dec_instr_o, (cnt != 0) ? instr_of(pc) : 32'h0);
        check({name, ".ready"}, 32'(fetch_ready_o), 32'(fr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] next_push;
        logic [31:0] exp_pop;
        int          model_cnt;
        logic        model_fr;

        //                rst   flush valid  pc0           pc1           rdy  cnt v     head          fr
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 0, 1'b0, 32'h0,        1'b1};
        vecs[1]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0100, 32'h0000_0104, 1'b0, 2, 1'b1, 32'h0000_0100, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 2'b01, 32'h0000_0108, 32'hDEAD_0000, 1'b0, 3, 1'b1, 32'h0000_0100, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 2'b10, 32'hDEAD_0004, 32'h0000_010C, 1'b0, 4, 1'b1, 32'h0000_0100, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 3, 1'b1, 32'h0000_0104, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0110, 32'h0000_0114, 1'b1, 4, 1'b1, 32'h0000_0108, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0118, 32'h0000_011C, 1'b0, 6, 1'b1, 32'h0000_0108, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0120, 32'h0000_0124, 1'b0, 8, 1'b1, 32'h0000_0108, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0200, 32'h0000_0204, 1'b0, 8, 1'b1, 32'h0000_0108, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 7, 1'b1, 32'h0000_010C, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 2'b11, 32'h0000_0300, 32'h0000_0304, 1'b1, 6, 1'b1, 32'h0000_0110, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 5, 1'b1, 32'h0000_0114, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 2'b11, 32'h0000_0400, 32'h0000_0404, 1'b1, 0, 1'b0, 32'h0,        1'b1};
        vecs[13] = '{1'b0, 1'b0, 2'b01, 32'h1C00_0100, 32'h0,        1'b0, 1, 1'b1, 32'h1C00_0100, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 0, 1'b0, 32'h0,        1'b1};
        vecs[15] = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 0, 1'b0, 32'h0,        1'b1};
        vecs[16] = '{1'b0, 1'b0, 2'b11, 32'h0000_0500, 32'h0000_0504, 1'b0, 2, 1'b1, 32'h0000_0500, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 2'b11, 32'h0000_0600, 32'h0000_0604, 1'b1, 0, 1'b0, 32'h0,        1'b1};

        idle();
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].valid, vecs[i].pc0, vecs[i].pc1, vecs[i].rdy);
            tick();
            check_head($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_pc, vecs[i].exp_fr);
        end
        idle();

        // First push after reset with the reference instruction words.
        do_reset();
        rst              = 1'b0;
        fetch_valid_i    = 2'b11;
        fetch_instr_i[0] = 32'h0280_0000;
        fetch_instr_i[1] = 32'h0280_0401;
        fetch_pc_i[0]    = 32'h1C00_0000;
        fetch_pc_i[1]    = 32'h1C00_0004;
        tick();
        idle();
        check("first.count", 32'(count_o), 32'd2);
        check("first.valid", 32'(dec_valid_o), 32'd1);
        check("first.instr", dec_instr_o, 32'h0280_0000);
        check("first.pc", dec_pc_o, 32'h1C00_0000);
        dec_ready_i = 1'b1;
        tick();
        idle();
        check("first.lane1_instr", dec_instr_o, 32'h0280_0401);
        check("first.lane1_pc", dec_pc_o, 32'h1C00_0004);

        // Lone lane-1 push into an empty buffer.
        do_reset();
        drive(1'b0, 1'b0, 2'b10, 32'hBAD0_0000, 32'h1C00_0024, 1'b0);
        tick();
        idle();
        check_head("lane1_only", 1, 32'h1C00_0024, 1'b1);

        // Fill to DEPTH, reject a fifth packet, then drain to re-open.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 2'b11, 32'h1C00_0200 + 32'(8 * k), 32'h1C00_0204 + 32'(8 * k), 1'b0);
            tick();
        end
        check_head("fill", 8, 32'h1C00_0200, 1'b0);
        drive(1'b0, 1'b0, 2'b11, 32'h1C00_0F00, 32'h1C00_0F04, 1'b0);
        tick();
        check_head("fill.fifth", 8, 32'h1C00_0200, 1'b0);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        tick();
        check_head("fill.pop1", 7, 32'h1C00_0204, 1'b0);
        tick();
        check_head("fill.pop2", 6, 32'h1C00_0208, 1'b1);
        idle();

        // Steady state from count 3: push pairs (while accepted) and pop every cycle,
        // crossing the 7 -> 0 index wrap with a two-lane push at tail 7.
        do_reset();
        drive(1'b0, 1'b0, 2'b11, 32'h1C00_0000, 32'h1C00_0004, 1'b0);
        tick();
        drive(1'b0, 1'b0, 2'b01, 32'h1C00_0008, 32'h0, 1'b0);
        tick();
        next_push = 32'h1C00_000C;
        exp_pop   = 32'h1C00_0000;
        model_cnt = 3;
        for (int c = 0; c < 10; c++) begin
            model_fr = (model_cnt <= DEPTH - 2);
            check($sformatf("steady%0d.count", c), 32'(count_o), 32'(model_cnt));
            check($sformatf("steady%0d.ready", c), 32'(fetch_ready_o), 32'(model_fr));
            check($sformatf("steady%0d.pc", c), dec_pc_o, exp_pop);
            drive(1'b0, 1'b0, model_fr ? 2'b11 : 2'b00, next_push, next_push + 32'd4, 1'b1);
            tick();
            if (model_fr) begin
                next_push = next_push + 32'd8;
                model_cnt = model_cnt + 2;
            end
            model_cnt = model_cnt - 1;
            exp_pop   = exp_pop + 32'd4;
        end
        idle();
        check_head("steady.end", model_cnt, exp_pop, model_cnt <= DEPTH - 2);

        // Mid-operation reset overrides push, pop and flush.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 2'b11, 32'h1C00_0700 + 32'(8 * k), 32'h1C00_0704 + 32'(8 * k), 1'b0);
            tick();
        end
        check_head("rst.before", 6, 32'h1C00_0700, 1'b1);
        drive(1'b1, 1'b1, 2'b11, 32'h1C00_0800, 32'h1C00_0804, 1'b1);
        tick();
        idle();
        check_head("rst.after", 0, 32'h0, 1'b1);
        tick();
        check_head("rst.idle", 0, 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
